aes_inv_cipher_seq: RTL and testbench

- Iterative AES-128 decryptor; the inverse counterpart of the team's AES-128 encryption core.
- Accepts a 128-bit cipher key and expands it to the final round key (rk10).
- Decrypts one 128-bit block per load, running the FIPS-197 inverse cipher one round per clock with an on-the-fly inverse key schedule.
- Sits beside the encryption core under the top-level wrapper and shares its key/text byte conventions.

---
 rtl/aes_inv_cipher_seq.sv | 257 +++++++++++++++++++++++++
 tb/tb_aes_inv_cipher_seq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_cipher_seq.sv
// Iterative AES-128 inverse cipher (decryptor), one round per clock.
//
// The key is expanded forward once to the last round key (rk10). Each block
// is then decrypted by walking the key schedule backwards on the fly, so no
// per-round key storage is needed.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   kld, key       key load strobe / 128-bit cipher key (key[127:120] = byte 0)
//   kdone          expanded key valid and no expansion running
//   ld, text_in    block load strobe / 128-bit ciphertext (column-major state)
//   busy           key expansion or decryption in progress
//   done           one-cycle pulse when text_out is updated
//   text_out       128-bit plaintext, held until the next done
//
// Handshake: kld and ld are single-cycle strobes sampled on the rising edge.
// kld is always accepted and restarts key expansion, aborting any decryption.
// ld is accepted only in READY, i.e. when busy=0 and kdone=1; otherwise it
// is dropped. done marks the only cycle in which text_out changes.
module aes_inv_cipher_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         kld,
    input  logic [127:0] key,
    output logic         kdone,
    input  logic         ld,
    input  logic [127:0] text_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] text_out
);

    typedef enum logic [1:0] {NOKEY, KEXP, READY, DEC} state_e;

    state_e       state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] wkey_q, wkey_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk10_q, rk10_d;
    logic [127:0] text_out_q, text_out_d;
    logic         busy_q, busy_d;
    logic         kdone_q, kdone_d;
    logic         done_q, done_d;

    logic [127:0] key_next;
    logic [127:0] key_prev;
    logic [127:0] round_out;

    // ---------------- GF(2^8) arithmetic, poly x^8+x^4+x^3+x+1 ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128 (maps 0 to 0).
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    // S-boxes built from the field inverse and the FIPS-197 affine maps.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // SubWord(RotWord(w)); w[31:24] is the first byte of the word.
    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Inverse step: the trailing words must be recovered first because the
    // leading word depends on the previous key's last word.
    function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] q0, q1, q2, q3;
        q3 = k[31:0] ^ k[63:32];
        q2 = k[63:32] ^ k[95:64];
        q1 = k[95:64] ^ k[127:96];
        q0 = k[127:96] ^ sub_rot(q3) ^ {rc, 24'h0};
        return {q0, q1, q2, q3};
    endfunction

    // InvShiftRows + InvSubBytes, AddRoundKey, then InvMixColumns unless last.
    function automatic logic [127:0] inv_round(input logic [127:0] s,
                                               input logic [127:0] rk,
                                               input logic         last);
        logic [127:0] t;
        logic [127:0] m;
        logic [7:0]   a0, a1, a2, a3;
        t = '0;
        m = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[127 - 8 * (4 * c + r) -: 8] =
                    inv_sbox(s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8]);
            end
        end
        t = t ^ rk;
        if (last) return t;
        for (int c = 0; c < 4; c++) begin
            a0 = t[127 - 32 * c -: 8];
            a1 = t[119 - 32 * c -: 8];
            a2 = t[111 - 32 * c -: 8];
            a3 = t[103 - 32 * c -: 8];
            m[127 - 32 * c -: 32] = {
                gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
        end
        return m;
    endfunction

    // ---------------- next-state logic ----------------
    always_comb begin
        // In KEXP rnd_q counts rounds done; in DEC it is the round index r.
        key_next  = key_fwd(wkey_q, rcon(rnd_q));
        key_prev  = key_inv(wkey_q, rcon(rnd_q));
        round_out = inv_round(st_q, key_prev, (rnd_q == 4'd0));

        state_d    = state_q;
        rnd_d      = rnd_q;
        wkey_d     = wkey_q;
        st_d       = st_q;
        rk10_d     = rk10_q;
        text_out_d = text_out_q;
        busy_d     = busy_q;
        kdone_d    = kdone_q;
        done_d     = 1'b0;

        if (kld) begin
            // kld has priority in every state and drops any concurrent ld.
            state_d = KEXP;
            wkey_d  = key;
            rnd_d   = 4'd0;
            busy_d  = 1'b1;
            kdone_d = 1'b0;
        end else begin
            case (state_q)
                NOKEY: ;
                KEXP: begin
                    wkey_d = key_next;
                    rnd_d  = 4'(rnd_q + 4'd1);
                    if (rnd_q == 4'd9) begin
                        rk10_d  = key_next;
                        state_d = READY;
                        busy_d  = 1'b0;
                        kdone_d = 1'b1;
                    end
                end
                READY: begin
                    if (ld) begin
                        state_d = DEC;
                        st_d    = text_in ^ rk10_q;
                        wkey_d  = rk10_q;
                        rnd_d   = 4'd9;
                        busy_d  = 1'b1;
                    end
                end
                DEC: begin
                    wkey_d = key_prev;
                    st_d   = round_out;
                    rnd_d  = 4'(rnd_q - 4'd1);
                    if (rnd_q == 4'd0) begin
                        text_out_d = round_out;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        state_d    = READY;
                    end
                end
                default: state_d = NOKEY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= NOKEY;
            rnd_q      <= 4'd0;
            wkey_q     <= '0;
            st_q       <= '0;
            rk10_q     <= '0;
            text_out_q <= '0;
            busy_q     <= 1'b0;
            kdone_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rnd_q      <= rnd_d;
            wkey_q     <= wkey_d;
            st_q       <= st_d;
            rk10_q     <= rk10_d;
            text_out_q <= text_out_d;
            busy_q     <= busy_d;
            kdone_q    <= kdone_d;
            done_q     <= done_d;
        end
    end

    assign kdone    = kdone_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign text_out = text_out_q;

endmodule

// File: tb/tb_aes_inv_cipher_seq.sv
// Directed bench for aes_inv_cipher_seq using FIPS-197 / SP800-38A vectors.
module tb_aes_inv_cipher_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         kld;
    logic [127:0] key;
    logic         kdone;
    logic         ld;
    logic [127:0] text_in;
    logic         busy;
    logic         done;
    logic [127:0] text_out;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] RK1  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] RK2  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] CT2A = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2A = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT2B = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] PT2B = 128'h6bc1bee22e409f96e93d7e117393172a;

    always #5 clk = ~clk;

    aes_inv_cipher_seq dut (
        .clk      (clk),
        .rst      (rst),
        .kld      (kld),
        .key      (key),
        .kdone    (kdone),
        .ld       (ld),
        .text_in  (text_in),
        .busy     (busy),
        .done     (done),
        .text_out (text_out)
    );

    // ---------------- driver / checking tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after the edge that sampled kld; watches until kdone rises.
    task automatic kexp_watch(output int nb, output int nk, output int nd);
        nb = 0;
        nk = 0;
        nd = 0;
        for (int i = 0; i < 30; i++) begin
            if (kdone) break;
            if (busy) nb++;
            if (done) nd++;
            nk++;
            tick();
        end
    endtask

    task automatic load_key(input string tag, input logic [127:0] k);
        int nb, nk, nd;
        kld = 1'b1;
        key = k;
        tick();
        kld = 1'b0;
        kexp_watch(nb, nk, nd);
        check({tag, "_busy_cycles"}, 128'(nb), 128'd10);
        check({tag, "_kdone_low_cycles"}, 128'(nk), 128'd10);
        check({tag, "_kdone"}, 128'(kdone), 128'd1);
        check({tag, "_busy_end"}, 128'(busy), 128'd0);
    endtask

    // Called just after the edge that sampled ld; counts edges until done.
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (done) break;
        end
    endtask

    task automatic watch_idle(input int cycles, output int nd, output int nb);
        nd = 0;
        nb = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done) nd++;
            if (busy) nb++;
        end
    endtask

    task automatic decrypt(input string tag, input logic [127:0] ct, input logic [127:0] pt);
        int n;
        ld      = 1'b1;
        text_in = ct;
        tick();
        ld = 1'b0;
        wait_done(n);
        check({tag, "_latency"}, 128'(n), 128'd10);
        check({tag, "_text_out"}, text_out, pt);
        check({tag, "_kdone_held"}, 128'(kdone), 128'd1);
        tick();
        check({tag, "_done_pulse"}, 128'(done), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n, nb, nk, nd;
        rst     = 1'b1;
        kld     = 1'b0;
        ld      = 1'b0;
        key     = '0;
        text_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_kdone", 128'(kdone), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_text_out", text_out, 128'd0);
        rst = 1'b0;
        tick();

        // ld before any key is loaded is ignored
        ld      = 1'b1;
        text_in = CT1;
        tick();
        ld = 1'b0;
        watch_idle(15, nd, nb);
        check("nokey_ld_done", 128'(nd), 128'd0);
        check("nokey_ld_busy", 128'(nb), 128'd0);
        check("nokey_text_out", text_out, 128'd0);

        // FIPS-197 C.1
        load_key("k1", K1);
        check("k1_rk10", dut.rk10_q, RK1);
        decrypt("c1", CT1, PT1);

        // FIPS-197 Appendix B
        load_key("k2", K2);
        check("k2_rk10", dut.rk10_q, RK2);
        decrypt("b", CT2A, PT2A);

        // back-to-back: second ld issued in the done cycle
        ld      = 1'b1;
        text_in = CT2B;
        tick();
        ld = 1'b0;
        wait_done(n);
        check("b2b_first_latency", 128'(n), 128'd10);
        check("b2b_first_text", text_out, PT2B);
        ld      = 1'b1;
        text_in = CT2A;
        tick();
        ld = 1'b0;
        wait_done(n);
        check("b2b_gap", 128'(n + 1), 128'd11);
        check("b2b_second_text", text_out, PT2A);
        check("b2b_rk10", dut.rk10_q, RK2);

        // ld during DEC cycle 5 is ignored
        ld      = 1'b1;
        text_in = CT2B;
        tick();
        ld = 1'b0;
        repeat (4) tick();
        ld      = 1'b1;
        text_in = CT1;
        tick();
        ld = 1'b0;
        wait_done(n);
        check("midld_latency", 128'(n + 5), 128'd10);
        check("midld_text", text_out, PT2B);
        watch_idle(15, nd, nb);
        check("midld_extra_done", 128'(nd), 128'd0);
        check("midld_text_hold", text_out, PT2B);

        // kld at DEC cycle 4 aborts the block
        ld      = 1'b1;
        text_in = CT2A;
        tick();
        ld = 1'b0;
        repeat (3) tick();
        kld = 1'b1;
        key = K1;
        tick();
        kld = 1'b0;
        kexp_watch(nb, nk, nd);
        check("abort_done", 128'(nd), 128'd0);
        check("abort_kdone_low_cycles", 128'(nk), 128'd10);
        check("abort_text_hold", text_out, PT2B);
        check("abort_rk10", dut.rk10_q, RK1);
        decrypt("abort_next", CT1, PT1);

        // kld and ld together: kld wins
        kld     = 1'b1;
        key     = K2;
        ld      = 1'b1;
        text_in = CT2A;
        tick();
        kld = 1'b0;
        ld  = 1'b0;
        kexp_watch(nb, nk, nd);
        check("kld_ld_done", 128'(nd), 128'd0);
        check("kld_ld_busy_cycles", 128'(nb), 128'd10);
        check("kld_ld_rk10", dut.rk10_q, RK2);
        decrypt("kld_ld_next", CT2A, PT2A);

        // asynchronous reset mid-KEXP
        kld = 1'b1;
        key = K1;
        tick();
        kld = 1'b0;
        repeat (5) tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", 128'(busy), 128'd0);
        check("arst_kdone", 128'(kdone), 128'd0);
        check("arst_done", 128'(done), 128'd0);
        check("arst_text_out", text_out, 128'd0);
        check("arst_rk10", dut.rk10_q, 128'd0);
        tick();
        rst = 1'b0;
        tick();
        ld      = 1'b1;
        text_in = CT1;
        tick();
        ld = 1'b0;
        watch_idle(15, nd, nb);
        check("arst_ld_done", 128'(nd), 128'd0);
        check("arst_ld_busy", 128'(nb), 128'd0);
        load_key("k1_again", K1);
        decrypt("arst_next", CT1, PT1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
